// File: rtl/gsram_pkg.sv
// Shared gSRAM geometry and write-sequencer state encoding, also used by the
// gSRAM model and the readout block.
package gsram_pkg;
  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int CW   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;
endpackage

// File: rtl/raster_addr_ctr.sv
// Raster-order (row-major) write address counter for the gSRAM fill pass.
// Parks on the final cell instead of wrapping back to (0,0).
module raster_addr_ctr #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last
);
  localparam logic [AW-1:0] LAST_R = AW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_C = AW'(COLS - 1);

  assign last = (row == LAST_R) && (col == LAST_C);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc && !last) begin
      if (col == LAST_C) begin
        col <= '0;
        row <= row + AW'(1);
      end else begin
        col <= col + AW'(1);
      end
    end
  end
endmodule

// File: rtl/gsram_wr_seq.sv
// gSRAM write sequencer: turns an m2 or LUT valid/ready word stream into one
// raster-ordered gSRAM write per accepted word; lends the address bus to the reader when idle.
module gsram_wr_seq #(
  parameter int ROWS = gsram_pkg::ROWS,
  parameter int COLS = gsram_pkg::COLS,
  parameter int AW   = gsram_pkg::AW,
  parameter int CW   = gsram_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          src_sel,
  input  logic          abort,
  input  logic          m2_valid,
  output logic          m2_ready,
  input  logic          lut_valid,
  output logic          lut_ready,
  input  logic [AW-1:0] rd_row,
  input  logic [AW-1:0] rd_col,
  output logic          we,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          inmuxsel,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);
  import gsram_pkg::*;

  localparam logic [CW-1:0] FULL = CW'(ROWS * COLS);

  seq_state_t    state;
  logic          sel_q, done_q;
  logic [CW-1:0] cnt;
  logic [AW-1:0] wr_row, wr_col;
  logic          last, run, rdy, sel_valid, fire, accept;

  assign run       = (state == RUN);
  assign accept    = (state == IDLE) && start;
  // abort wins over a pending handshake: drop ready so the source keeps its word
  assign rdy       = run && !abort;
  assign sel_valid = sel_q ? lut_valid : m2_valid;
  assign fire      = rdy && sel_valid;

  raster_addr_ctr #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (fire),
    .row   (wr_row),
    .col   (wr_col),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel_q  <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sel_q <= src_sel;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (fire) begin
            if (cnt != FULL) cnt <= cnt + CW'(1);
            if (last) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m2_ready  = rdy && !sel_q;
  assign lut_ready = rdy && sel_q;
  assign we        = fire;
  assign row       = run ? wr_row : rd_row;
  assign col       = run ? wr_col : rd_col;
  assign inmuxsel  = sel_q;
  assign busy      = run;
  assign done      = done_q;
  assign count     = cnt;
endmodule
